// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the 7-segment scan decoder:
//                digit segment codes, special nibbles and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // Active-high segment patterns {g,f,e,d,c,b,a}; index = decimal digit
   localparam logic [9:0][6:0] SEG_CODES = {
      7'h6F,   // 9
      7'h7F,   // 8
      7'h07,   // 7
      7'h7D,   // 6
      7'h6D,   // 5
      7'h66,   // 4
      7'h4F,   // 3
      7'h5B,   // 2
      7'h06,   // 1
      7'h3F    // 0
   };

   localparam logic [6:0] SEG_BLANK    = 7'h00;
   localparam logic [3:0] BLANK_NIBBLE = 4'hF;
   localparam logic [3:0] ERR_NIBBLE   = 4'hE;
   localparam int         NUM_DIGITS   = 4;

   typedef enum logic [1:0] {
      ST_SETTLE  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational active-high segment pattern to BCD nibble
//                decoder. All-off decodes to the blank nibble; anything that
//                is not a digit or blank decodes to the error nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_nibble,
   output logic       o_err
);

   // Table lookup against the shared digit codes; error is the fallthrough
   always_comb begin
      o_nibble = ERR_NIBBLE;
      o_err    = 1'b1;
      if (i_seg == SEG_BLANK) begin
         o_nibble = BLANK_NIBBLE;
         o_err    = 1'b0;
      end
      for (int d = 0; d < 10; d++) begin
         if (i_seg == SEG_CODES[d]) begin
            o_nibble = 4'(d);
            o_err    = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Snoops a multiplexed 4-digit 7-segment display bus, debounces
//                each digit dwell, decodes it and publishes complete frames as
//                packed BCD with sign and error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter int unsigned STABLE_CYCLES  = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  i_segments,
   input  logic [3:0]  i_display_select,
   input  logic        i_sign,
   output logic [15:0] o_value_bcd,
   output logic        o_value_sign,
   output logic        o_frame_valid,
   output logic        o_digit_error
);

   localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

   // Normalised (active-high) view of the display bus
   logic [6:0]            w_seg_ah;
   logic [3:0]            w_sel_ah;
   logic [11:0]           w_sample;
   logic                  w_same;
   logic [7:0]            w_cnt_nxt;
   logic                  w_accept;
   logic                  w_onehot;
   logic [3:0]            w_dec_nib;
   logic                  w_dec_err;
   logic [NUM_DIGITS-1:0] w_seen_nxt;

   logic [11:0]                 r_sample;
   logic [7:0]                  r_cnt;
   state_t                      r_state;
   logic [NUM_DIGITS-1:0]       r_seen;
   logic [NUM_DIGITS-1:0]       r_err;
   logic [NUM_DIGITS-1:0][3:0]  r_slots;
   logic                        r_sign;
   logic [15:0]                 r_value_bcd;
   logic                        r_value_sign;
   logic                        r_frame_valid;
   logic                        r_digit_error;

   assign w_seg_ah   = SEG_ACTIVE_LOW ? ~i_segments       : i_segments;
   assign w_sel_ah   = SEL_ACTIVE_LOW ? ~i_display_select : i_display_select;
   assign w_sample   = {w_seg_ah, w_sel_ah, i_sign};
   assign w_same     = (w_sample == r_sample);
   assign w_onehot   = $onehot(w_sel_ah);
   assign w_seen_nxt = r_seen | w_sel_ah;

   // Accept fires on the cycle the count reaches its target, so only once
   // per dwell: the FSM leaves SETTLE on that same edge
   assign w_accept   = (r_state == ST_SETTLE) && (w_cnt_nxt == c_STABLE);

   // Next stability count: restart on change, otherwise saturating increment
   always_comb begin
      w_cnt_nxt = 8'd1;
      if (w_same) begin
         w_cnt_nxt = (r_cnt >= c_STABLE) ? c_STABLE : r_cnt + 8'd1;
      end
   end

   seg7_decode u_decode (
      .i_seg    (w_seg_ah),
      .o_nibble (w_dec_nib),
      .o_err    (w_dec_err)
   );

   // Sample register and stability counter, running in every FSM state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample <= '0;
         r_cnt    <= '0;
      end else begin
         r_sample <= w_sample;
         r_cnt    <= w_cnt_nxt;
      end
   end

   // Frame assembly FSM with registered frame outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_SETTLE;
         r_seen        <= '0;
         r_err         <= '0;
         r_slots       <= '0;
         r_sign        <= 1'b0;
         r_value_bcd   <= '0;
         r_value_sign  <= 1'b0;
         r_frame_valid <= 1'b0;
         r_digit_error <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         case (r_state)
            ST_SETTLE: begin
               if (w_accept) begin
                  r_state <= ST_HOLD;
                  // Zero or multiple selects are ghosting/blanking: drop them
                  if (w_onehot) begin
                     for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (w_sel_ah[k]) begin
                           r_slots[k] <= w_dec_nib;
                           r_err[k]   <= w_dec_err;
                        end
                     end
                     r_seen <= w_seen_nxt;
                     r_sign <= i_sign;
                     if (&w_seen_nxt) begin
                        r_state <= ST_PUBLISH;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (!w_same) begin
                  r_state <= ST_SETTLE;
               end
            end
            ST_PUBLISH: begin
               r_value_bcd   <= r_slots;
               r_value_sign  <= r_sign;
               r_digit_error <= |r_err;
               r_frame_valid <= 1'b1;
               r_seen        <= '0;
               r_err         <= '0;
               r_state       <= w_same ? ST_HOLD : ST_SETTLE;
            end
            default: begin
               r_state <= ST_SETTLE;
            end
         endcase
      end
   end

   assign o_value_bcd   = r_value_bcd;
   assign o_value_sign  = r_value_sign;
   assign o_frame_valid = r_frame_valid;
   assign o_digit_error = r_digit_error;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_decoder
//  Description : Directed self-checking bench for seg7_scan_decoder with
//                default parameters (active-low bus, 4-cycle debounce).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  i_segments;
   logic [3:0]  i_display_select;
   logic        i_sign;
   logic [15:0] o_value_bcd;
   logic        o_value_sign;
   logic        o_frame_valid;
   logic        o_digit_error;

   int n_vec   = 0;
   int n_err   = 0;
   int cyc     = 0;
   int fv_cnt  = 0;
   int fv_cyc  = 0;
   int app_cyc = 0;

   // Active-high digit patterns 0..9
   logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   seg7_scan_decoder u_dut (
      .clk              (clk),
      .rst              (rst),
      .i_segments       (i_segments),
      .i_display_select (i_display_select),
      .i_sign           (i_sign),
      .o_value_bcd      (o_value_bcd),
      .o_value_sign     (o_value_sign),
      .o_frame_valid    (o_frame_valid),
      .o_digit_error    (o_digit_error)
   );

   always #5 clk = ~clk;

   // Cycle counter and frame_valid pulse monitor, sampled just after each edge
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (o_frame_valid) begin
         fv_cnt = fv_cnt + 1;
         fv_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one active-high bus state (inverted onto the active-low pins) for n cycles
   task automatic apply(input logic [6:0] seg_ah, input logic [3:0] sel_ah,
                        input logic sgn, input int n);
      i_segments       = ~seg_ah;
      i_display_select = ~sel_ah;
      i_sign           = sgn;
      app_cyc          = cyc;
      repeat (n) @(negedge clk);
   endtask

   task automatic digit(input int slot, input logic [6:0] seg_ah, input logic sgn);
      apply(seg_ah, 4'(1 << slot), sgn, 6);
   endtask

   task automatic idle(input int n);
      apply(7'h00, 4'h0, 1'b0, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b1;
      i_segments       = 7'h7F;
      i_display_select = 4'hF;
      i_sign           = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bcd",  32'(o_value_bcd),   32'h0);
      chk("rst_sign", 32'(o_value_sign),  32'h0);
      chk("rst_fv",   32'(o_frame_valid), 32'h0);
      chk("rst_err",  32'(o_digit_error), 32'h0);
      rst = 1'b0;
      idle(4);

      // Basic scan 1,2,4,8
      fv_cnt = 0;
      digit(0, pat[1], 1'b0);
      digit(1, pat[2], 1'b0);
      digit(2, pat[4], 1'b0);
      digit(3, pat[8], 1'b0);
      chk("t1_pulses",  32'(fv_cnt),        32'd1);
      chk("t1_latency", 32'(fv_cyc - app_cyc), 32'd5);
      chk("t1_bcd",     32'(o_value_bcd),   32'h8421);
      chk("t1_sign",    32'(o_value_sign),  32'h0);
      chk("t1_err",     32'(o_digit_error), 32'h0);

      // Negative value 5,1,0,0
      fv_cnt = 0;
      digit(0, pat[5], 1'b1);
      digit(1, pat[1], 1'b1);
      digit(2, pat[0], 1'b1);
      digit(3, pat[0], 1'b1);
      chk("t2_pulses",  32'(fv_cnt),        32'd1);
      chk("t2_latency", 32'(fv_cyc - app_cyc), 32'd5);
      chk("t2_bcd",     32'(o_value_bcd),   32'h0015);
      chk("t2_sign",    32'(o_value_sign),  32'h1);

      // Short glitch on digit 2 is not accepted; corrected value wins
      fv_cnt = 0;
      digit(0, pat[3], 1'b0);
      digit(1, pat[7], 1'b0);
      apply(pat[9], 4'b0100, 1'b0, 3);
      digit(2, pat[6], 1'b0);
      chk("t3_no_early", 32'(fv_cnt), 32'd0);
      digit(3, pat[2], 1'b0);
      chk("t3_pulses", 32'(fv_cnt),      32'd1);
      chk("t3_bcd",    32'(o_value_bcd), 32'h2673);

      // Undecodable digit 1 and a blank digit 2, then a clean frame
      fv_cnt = 0;
      digit(0, pat[9], 1'b0);
      digit(1, 7'h01,  1'b0);
      digit(2, 7'h00,  1'b0);
      digit(3, pat[4], 1'b0);
      chk("t4_pulses", 32'(fv_cnt),        32'd1);
      chk("t4_bcd",    32'(o_value_bcd),   32'h4FE9);
      chk("t4_err",    32'(o_digit_error), 32'h1);
      fv_cnt = 0;
      digit(0, pat[1], 1'b0);
      digit(1, pat[2], 1'b0);
      digit(2, pat[4], 1'b0);
      digit(3, pat[8], 1'b0);
      chk("t4_clean_bcd", 32'(o_value_bcd),   32'h8421);
      chk("t4_clean_err", 32'(o_digit_error), 32'h0);

      // Multi-bit and zero selects must not fill any slot
      fv_cnt = 0;
      apply(pat[8], 4'b0011, 1'b0, 10);
      apply(pat[8], 4'b0000, 1'b0, 10);
      chk("t5_multi_fv", 32'(fv_cnt), 32'd0);
      digit(2, pat[5], 1'b0);
      digit(3, pat[6], 1'b0);
      chk("t5_half_fv", 32'(fv_cnt), 32'd0);
      digit(0, pat[7], 1'b0);
      digit(1, pat[8], 1'b0);
      chk("t5_pulses", 32'(fv_cnt),      32'd1);
      chk("t5_bcd",    32'(o_value_bcd), 32'h6587);

      // Reset mid-frame discards digits 0 and 1
      fv_cnt = 0;
      digit(0, pat[1], 1'b1);
      digit(1, pat[2], 1'b1);
      i_segments       = 7'h7F;
      i_display_select = 4'hF;
      i_sign           = 1'b0;
      rst              = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_rst_bcd",  32'(o_value_bcd),   32'h0);
      chk("t6_rst_sign", 32'(o_value_sign),  32'h0);
      chk("t6_rst_fv",   32'(o_frame_valid), 32'h0);
      rst = 1'b0;
      idle(6);
      digit(2, pat[3], 1'b0);
      digit(3, pat[4], 1'b0);
      chk("t6_half_fv", 32'(fv_cnt), 32'd0);
      digit(0, pat[5], 1'b0);
      digit(1, pat[6], 1'b0);
      chk("t6_pulses", 32'(fv_cnt),       32'd1);
      chk("t6_bcd",    32'(o_value_bcd),  32'h4365);
      chk("t6_sign",   32'(o_value_sign), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SEG_ACTIVE_LOW, default 1: segments input is active-low when 1.
REQ-002 SHALL have parameter SEL_ACTIVE_LOW, default 1: display_select input is active-low when 1.
REQ-003 SHALL have parameter STABLE_CYCLES, default 4, legal range 2..255: consecutive identical samples required to accept a digit.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 segments  input  7  bit order {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-007 display_select  input  4  digit enable; bit 0 = least significant digit; polarity per SEL_ACTIVE_LOW.
REQ-008 sign  input  1  active-high negative flag from the display driver.
REQ-009 value_bcd  output  16  last complete frame; nibble k = digit k.
REQ-010 value_sign  output  1  sign captured with the last complete frame.
REQ-011 frame_valid  output  1  one-cycle pulse when value_bcd/value_sign update.
REQ-012 digit_error  output  1  set if any digit of the published frame had an undecodable pattern; held until next publish.

Function
REQ-013 SHALL normalize segments and display_select to active-high internally before any comparison.
REQ-014 SHALL register the normalized {segments, display_select, sign} every cycle; stability counter resets to 1 when the sample differs from the previous one, else increments, saturating at STABLE_CYCLES.
REQ-015 FSM states: SETTLE (counting), HOLD (sample accepted, waiting for change), PUBLISH (one cycle).
REQ-016 SETTLE -> HOLD on the cycle the counter reaches STABLE_CYCLES, producing exactly one accept per dwell; HOLD -> SETTLE on any sample change.
REQ-017 On accept with display_select not one-hot (zero or multiple bits), SHALL discard the sample: no slot write, no error.
REQ-018 On accept with one-hot select, SHALL write the decoded nibble into that slot, set its seen bit, latch sign, and record the slot's error bit.
REQ-019 Decode SHALL map the active-high patterns 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F to 0-9, all-off (0x00) to 0xF (blank), and any other pattern to 0xE with the error bit set.
REQ-020 A revisit of an already-seen slot before the frame completes SHALL overwrite its nibble and error bit.
REQ-021 When an accept makes seen == 4'b1111, the FSM SHALL enter PUBLISH on the next cycle, drive value_bcd, value_sign and digit_error, pulse frame_valid for exactly one cycle, and clear seen and error bits.
REQ-022 PUBLISH SHALL return to HOLD if the sample is unchanged, else to SETTLE; the stability counter keeps running through PUBLISH.
REQ-023 Latency: frame_valid SHALL assert exactly STABLE_CYCLES+1 cycles after the fourth distinct digit's sample first appears on the inputs.
REQ-024 value_bcd, value_sign, digit_error SHALL change only in the PUBLISH cycle.

Reset
REQ-025 While rst is high: value_bcd = 16'h0000, value_sign = 0, frame_valid = 0, digit_error = 0, seen = 0, counter = 0, state = SETTLE.
REQ-026 Reset asserted mid-frame SHALL discard all partially captured digits; the next frame starts from empty.

Structure
REQ-027 Package seg7_pkg SHALL hold the ten digit segment codes, BLANK_NIBBLE = 4'hF, ERR_NIBBLE = 4'hE, NUM_DIGITS = 4, and the FSM state enum.
REQ-028 Pattern-to-nibble decode SHALL be a separate combinational sub-module seg7_decode shared with seg7_pkg codes.

Verification (10 ns clock, defaults)
REQ-029 Scan digits 0..3 with patterns for 1,2,4,8, sign = 0, 6 cycles each -> one frame_valid pulse, value_bcd = 16'h8421, value_sign = 0, digit_error = 0.
REQ-030 Same scan with sign = 1 and patterns 5,1,0,0 -> value_bcd = 16'h0015, value_sign = 1.
REQ-031 Digit 2 pattern held only 3 cycles, then corrected and held 6 -> no premature publish; frame contains corrected digit.
REQ-032 Digit 1 pattern 0x01 (active-high) -> value_bcd nibble 1 = 0xE, digit_error = 1; next clean frame clears digit_error.
REQ-033 display_select = 4'b0011 (active-high after normalization) held 10 cycles -> no slot written, no frame_valid.
REQ-034 rst pulsed after digits 0 and 1 captured -> outputs zero; publishing requires all four digits again.
